// File: rtl/rd_arb.sv
// Two-client round-robin read arbiter in front of a single in-order memory read bus.
// A tag FIFO remembers which client issued each outstanding read so responses are routed back with the address.
module rd_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int OST_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         imap_req,
    input  logic [AW-1:0]                imap_addr,
    input  logic                         imap_vld,
    output logic                         imap_rdy,
    output logic [AW-1:0]                imap_rsp_addr,
    output logic [DW-1:0]                imap_rsp_data,
    output logic                         imap_rsp_vld,
    input  logic                         imap_rsp_rdy,
    input  logic                         wgt_req,
    input  logic [AW-1:0]                wgt_addr,
    input  logic                         wgt_vld,
    output logic                         wgt_rdy,
    output logic [AW-1:0]                wgt_rsp_addr,
    output logic [DW-1:0]                wgt_rsp_data,
    output logic                         wgt_rsp_vld,
    input  logic                         wgt_rsp_rdy,
    output logic [AW-1:0]                mem_addr,
    output logic                         mem_vld,
    input  logic                         mem_rdy,
    input  logic [DW-1:0]                mem_rsp_data,
    input  logic                         mem_rsp_vld,
    output logic                         mem_rsp_rdy,
    output logic [$clog2(OST_DEPTH):0]   ost_cnt,
    output logic                         rsp_err
);

    localparam int PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int CW = $clog2(OST_DEPTH) + 1;

    typedef enum logic {
        CL_IMAP = 1'b0,
        CL_WGT  = 1'b1
    } client_t;

    client_t       fifo_id   [OST_DEPTH];
    logic [AW-1:0] fifo_addr [OST_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    client_t       rr;
    client_t       gnt;
    client_t       head_id;
    logic [AW-1:0] head_addr;
    logic          imap_elig;
    logic          wgt_elig;
    logic          any_elig;
    logic          fifo_full;
    logic          fifo_empty;
    logic          issue;
    logic          pop;

    always_comb begin
        imap_elig  = imap_req & imap_vld;
        wgt_elig   = wgt_req & wgt_vld;
        any_elig   = imap_elig | wgt_elig;
        // A lone eligible client wins; rr only breaks ties.
        gnt        = (wgt_elig & (~imap_elig | (rr == CL_WGT))) ? CL_WGT : CL_IMAP;
        fifo_full  = (ost_cnt == CW'(OST_DEPTH));
        fifo_empty = (ost_cnt == '0);

        mem_vld    = any_elig & ~fifo_full;
        mem_addr   = '0;
        if (any_elig)
            mem_addr = (gnt == CL_WGT) ? wgt_addr : imap_addr;
        imap_rdy   = imap_elig & (gnt == CL_IMAP) & mem_rdy & ~fifo_full;
        wgt_rdy    = wgt_elig & (gnt == CL_WGT) & mem_rdy & ~fifo_full;
        issue      = mem_vld & mem_rdy;

        head_id       = fifo_id[rd_ptr];
        head_addr     = fifo_addr[rd_ptr];
        imap_rsp_vld  = mem_rsp_vld & ~fifo_empty & (head_id == CL_IMAP);
        wgt_rsp_vld   = mem_rsp_vld & ~fifo_empty & (head_id == CL_WGT);
        imap_rsp_addr = head_addr;
        wgt_rsp_addr  = head_addr;
        imap_rsp_data = mem_rsp_data;
        wgt_rsp_data  = mem_rsp_data;
        mem_rsp_rdy   = ~fifo_empty & ((head_id == CL_WGT) ? wgt_rsp_rdy : imap_rsp_rdy);
        pop           = mem_rsp_vld & mem_rsp_rdy;
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_id[wr_ptr]   <= gnt;
            fifo_addr[wr_ptr] <= mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ost_cnt <= '0;
            rr      <= CL_IMAP;
            rsp_err <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr     <= (gnt == CL_IMAP) ? CL_WGT : CL_IMAP;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({issue, pop})
                2'b10:   ost_cnt <= ost_cnt + 1'b1;
                2'b01:   ost_cnt <= ost_cnt - 1'b1;
                default: ost_cnt <= ost_cnt;
            endcase
            if (mem_rsp_vld & fifo_empty)
                rsp_err <= 1'b1;
        end
    end

endmodule
